// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the scanned BCD stopwatch.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } sw_state_t;

  // Active-high a..g patterns (bit 0 = a, bit 6 = g); entry 10 is blank.
  localparam logic [10:0][6:0] SEG_TABLE = {
    7'h00,  // blank
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  localparam int SEG_BLANK_IDX = 10;

  // Non-BCD codes cannot be produced by the counters but still map to blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    if (d <= 4'd9) return SEG_TABLE[d];
    else           return SEG_TABLE[SEG_BLANK_IDX];
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit (0..9) with enable, carry-in and combinational carry-out.
// Latency: q updates on the clock edge where en & cin; cout is combinational.
// Backpressure: none; clr has priority over counting.
// Ports: clk, rst (async, active-high), clr (sync zero), en, cin -> q[3:0], cout.
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  logic inc;

  assign inc  = en & cin;
  assign cout = inc & (q == 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_scan_n.sv
// N-digit BCD stopwatch (run/stop, clear, lap freeze) driving a scanned 7-segment display.
// Latency: DOUT/DSEL/OVF registered, one cycle after scan index or count change; RUNNING follows state.
// Backpressure: none; inputs are single-cycle pulses, priority CLEAR > START_STOP > LAP.
// Ports: CLK, RESET (async, active-high), START_STOP, CLEAR, LAP ->
//        DOUT[7:0] (active-low, [7]=dp), DSEL[DIGITS-1:0] (active-low one-hot), RUNNING, OVF.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros above DP_POS.
module stopwatch_scan_n
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 400000,
  parameter int SCAN_DIV = 10000,
  parameter int DP_POS   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START_STOP,
  input  logic              CLEAR,
  input  logic              LAP,
  output logic [7:0]        DOUT,
  output logic [DIGITS-1:0] DSEL,
  output logic              RUNNING,
  output logic              OVF
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  sw_state_t state, state_nxt;
  logic      lap_cap;
  logic      active;
  logic      tick;

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;

  logic [DIGITS-1:0][3:0] count_dig;
  logic [DIGITS-1:0][3:0] lap_dig;
  logic [DIGITS-1:0][3:0] disp_dig;
  logic [DIGITS:0]        carry;

  logic [3:0] cur_digit;
  logic       dp_on;
  logic       blank;

  // ---------------- run-control FSM ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lap_cap   = 1'b0;
    if (CLEAR) begin
      state_nxt = ST_IDLE;
    end else if (START_STOP) begin
      case (state)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_STOP;
        ST_STOP: state_nxt = ST_RUN;
        ST_LAP:  state_nxt = ST_STOP;
        default: state_nxt = ST_IDLE;
      endcase
    end else if (LAP) begin
      case (state)
        ST_RUN: begin
          state_nxt = ST_LAP;
          lap_cap   = 1'b1;
        end
        ST_LAP:  state_nxt = ST_RUN;
        default: state_nxt = state;
      endcase
    end
  end

  assign active  = (state == ST_RUN) || (state == ST_LAP);
  assign RUNNING = active;

  // ---------------- tick prescaler ----------------
  // Holds in STOP/IDLE so resuming keeps the partial tick.
  assign tick = active && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
    end else if (CLEAR) begin
      presc <= '0;
    end else if (active) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // ---------------- ripple BCD count ----------------
  assign carry[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk  (CLK),
      .rst  (RESET),
      .clr  (CLEAR),
      .en   (tick),
      .cin  (carry[k]),
      .q    (count_dig[k]),
      .cout (carry[k+1])
    );
  end

  // Lap register snapshots the pre-increment count on the RUN->LAP edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        lap_dig <= '0;
    else if (lap_cap) lap_dig <= count_dig;
  end

  assign disp_dig = (state == ST_LAP) ? lap_dig : count_dig;

  // ---------------- display scan ----------------
  // Free-running in every state; CLEAR deliberately does not touch it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign cur_digit = disp_dig[scan_idx];
  assign dp_on     = (int'(scan_idx) == DP_POS);

`ifdef LEADING_ZERO_BLANK_EN
  // hi_zero[k]: digit k and every digit above it are zero.
  logic [DIGITS-1:0] hi_zero;

  always_comb begin
    logic acc;
    acc     = 1'b1;
    hi_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc        = acc && (disp_dig[k] == 4'd0);
      hi_zero[k] = acc;
    end
  end

  assign blank = (int'(scan_idx) > DP_POS) && hi_zero[scan_idx];
`else
  assign blank = 1'b0;
`endif

  // ---------------- output registers ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DOUT <= 8'hFF;
      DSEL <= '1;
      OVF  <= 1'b0;
    end else begin
      DSEL <= ~(DIGITS'(1) << scan_idx);
      DOUT <= blank ? 8'hFF : {~dp_on, ~bcd_to_seg(cur_digit)};
      OVF  <= carry[DIGITS] && !CLEAR;
    end
  end

endmodule

// File: tb/tb_stopwatch_scan_n.sv
// Scoreboard bench: an arithmetic model pushes the expected output word every
// clock; a negedge monitor pops and compares it against the DUT outputs.
module tb_stopwatch_scan_n;

  localparam int D  = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int DP = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START_STOP = 1'b0;
  logic         CLEAR = 1'b0;
  logic         LAP = 1'b0;
  logic [7:0]   DOUT;
  logic [D-1:0] DSEL;
  logic         RUNNING;
  logic         OVF;

  stopwatch_scan_n #(
    .DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .DP_POS(DP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START_STOP(START_STOP), .CLEAR(CLEAR), .LAP(LAP),
    .DOUT(DOUT), .DSEL(DSEL), .RUNNING(RUNNING), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]   dout;
    logic [D-1:0] dsel;
    logic         run;
    logic         ovf;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // Model state: 0 idle, 1 run, 2 stop, 3 lap. Count held as a plain integer.
  int m_st = 0, m_cnt = 0, m_presc = 0, m_lap = 0, m_sidx = 0, m_scnt = 0;
  int m_ovf_total = 0;
  int dut_ovf_n = 0;

  function automatic int pow10(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference model, evaluated on each active edge from the inputs in force.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_st = 0; m_cnt = 0; m_presc = 0; m_lap = 0; m_sidx = 0; m_scnt = 0;
      q.delete();
    end else begin
      int disp, dig;
      bit act, tick, wrap;
      exp_t e;
      disp = (m_st == 3) ? m_lap : m_cnt;
      dig  = (disp / pow10(m_sidx)) % 10;
      e.dsel = ~(D'(1) << m_sidx);
      e.dout = {~(m_sidx == DP), ~seg(dig)};
`ifdef LEADING_ZERO_BLANK_EN
      if (m_sidx > DP && (disp / pow10(m_sidx)) == 0) e.dout = 8'hFF;
`endif
      act  = (m_st == 1) || (m_st == 3);
      tick = act && (m_presc == TD - 1);
      wrap = 1'b0;
      if (CLEAR) begin
        m_st = 0; m_cnt = 0; m_presc = 0;
      end else begin
        if (LAP && !START_STOP && m_st == 1) m_lap = m_cnt;
        if (act) m_presc = tick ? 0 : m_presc + 1;
        if (tick) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == pow10(D)) begin
            m_cnt = 0;
            wrap = 1'b1;
            m_ovf_total++;
          end
        end
        if (START_STOP) m_st = act ? 2 : 1;
        else if (LAP) begin
          if (m_st == 1) m_st = 3;
          else if (m_st == 3) m_st = 1;
        end
      end
      if (m_scnt == SD - 1) begin
        m_scnt = 0;
        m_sidx = (m_sidx + 1) % D;
      end else begin
        m_scnt = m_scnt + 1;
      end
      e.run = (m_st == 1) || (m_st == 3);
      e.ovf = wrap;
      q.push_back(e);
    end
  end

  // Monitor: one expected word per clock, checked away from the active edge.
  always @(negedge CLK) begin
    if (RESET) begin
      total++;
      if (DOUT !== 8'hFF || DSEL !== {D{1'b1}} || RUNNING !== 1'b0 || OVF !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold t=%0t dout=%h dsel=%b run=%b ovf=%b required ff/%b/0/0",
                 $time, DOUT, DSEL, RUNNING, OVF, {D{1'b1}});
      end
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (OVF === 1'b1) dut_ovf_n++;
      if (DOUT !== e.dout || DSEL !== e.dsel || RUNNING !== e.run || OVF !== e.ovf) begin
        bad++;
        $display("FAIL scoreboard t=%0t got dout=%h dsel=%b run=%b ovf=%b required dout=%h dsel=%b run=%b ovf=%b",
                 $time, DOUT, DSEL, RUNNING, OVF, e.dout, e.dsel, e.run, e.ovf);
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic c, input logic s, input logic l);
    @(negedge CLK);
    CLEAR = c; START_STOP = s; LAP = l;
    @(negedge CLK);
    CLEAR = 1'b0; START_STOP = 1'b0; LAP = 1'b0;
  endtask

  task automatic wait_cnt(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (m_cnt != target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (m_cnt != target) begin
      bad++;
      $display("FAIL %s timeout count=%0d required=%0d", name, m_cnt, target);
    end
  endtask

  initial begin
    // Reset, then idle: display scans zeros, nothing runs.
    idle(3);
    #1 RESET = 1'b0;
    idle(40);
    chk("idle_running", int'(RUNNING), 0);

    // Start and run for a while.
    drive(1'b0, 1'b1, 1'b0);
    idle(40);
    chk("run_running", int'(RUNNING), 1);

    // Run up to the wrap point, then through it.
    wait_cnt("reach_9999", 9999, 45000);
    wait_cnt("wrap_to_0", 0, 20);
    idle(3);
    chk("ovf_pulses", dut_ovf_n, m_ovf_total);
    chk("ovf_one_wrap", dut_ovf_n, 1);

    // Lap freeze at 0005, keep running, then release.
    wait_cnt("reach_5", 5, 100);
    drive(1'b0, 1'b0, 1'b1);
    idle(20);
    chk("lap_running", int'(RUNNING), 1);
    drive(1'b0, 1'b0, 1'b1);
    idle(20);

    // Stop, lap ignored in STOP, resume.
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    idle(10);
    chk("stop_running", int'(RUNNING), 0);
    drive(1'b0, 1'b1, 1'b0);
    idle(10);

    // CLEAR beats START_STOP on the same cycle.
    drive(1'b1, 1'b1, 1'b0);
    idle(10);
    chk("clear_running", int'(RUNNING), 0);

    // Asynchronous reset mid-count.
    drive(1'b0, 1'b1, 1'b0);
    idle(30);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async_dout", int'(DOUT), 8'hFF);
    chk("async_dsel", int'(DSEL), (1 << D) - 1);
    chk("async_running", int'(RUNNING), 0);
    idle(2);
    #1 RESET = 1'b0;
    idle(20);

    // Randomised pulses on all three controls.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      CLEAR      = ($urandom_range(0, 199) == 0);
      START_STOP = ($urandom_range(0, 29) == 0);
      LAP        = ($urandom_range(0, 19) == 0);
    end
    @(negedge CLK);
    CLEAR = 1'b0; START_STOP = 1'b0; LAP = 1'b0;
    idle(4);
    chk("ovf_total_final", dut_ovf_n, m_ovf_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_scan_n.md
Name: stopwatch_scan_n

Overview:
- Parametrised N-digit BCD stopwatch with start/stop, clear and lap-hold modes.
- Drives a time-multiplexed 7-segment display directly: one shared segment bus plus one-hot digit selects.
- Generalises the fixed 4-digit Watch100 stopwatch: parametrised digit count, tick rate and scan rate, plus run control and lap freeze.
- Sits between the debounced push-button logic and the board's 7-segment pins.

Parameters:
- DIGITS, 4: number of BCD digits and digit-select lines; legal range 2..8.
- TICK_DIV, 400000: CLK cycles per least-significant-digit increment (100 Hz at 40 MHz).
- SCAN_DIV, 10000: CLK cycles each digit stays selected.
- DP_POS, 2: digit index (0 = least significant) whose decimal point is lit.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- START_STOP  in  1  single-cycle pulse; toggles run/stop.
- CLEAR  in  1  single-cycle pulse; zero the count and stop.
- LAP  in  1  single-cycle pulse; toggles display freeze while counting.
- DOUT  out  8  segments, active-low; [6:0] = g..a, [7] = dp.
- DSEL  out  DIGITS  digit selects, active-low, one-hot; bit 0 = least significant digit.
- RUNNING  out  1  high in RUN or LAP.
- OVF  out  1  one-cycle pulse when the count wraps from all-9 to 0.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; count, prescaler and scan counter = 0; scan index = 0; lap register = 0.
  - DOUT = 8'hFF, DSEL = all ones, RUNNING = 0, OVF = 0.
- FSM states: IDLE, RUN, STOP, LAP.
  - IDLE --START_STOP--> RUN.
  - RUN --START_STOP--> STOP.
  - RUN --LAP--> LAP; the lap register captures the count on the same edge.
  - LAP --LAP--> RUN.
  - LAP --START_STOP--> STOP; the display returns to the live count.
  - STOP --START_STOP--> RUN.
  - STOP --LAP--> no effect.
  - CLEAR from any state --> IDLE; count and prescaler = 0.
- Input priority on the same cycle: CLEAR > START_STOP > LAP.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - Holds its value in STOP, so a pause loses no fractional tick.
  - Tick asserts on the cycle it equals TICK_DIV-1.
- Count:
  - DIGITS-wide ripple BCD; digit k increments when all lower digits are 9 and a tick occurs.
  - All-9 plus tick wraps to all-0, OVF = 1 for that single cycle, and counting continues.
- Display source: the lap register in LAP, the live count otherwise.
- Scan:
  - The scan counter cycles 0..SCAN_DIV-1 in every state, IDLE included, and is unaffected by CLEAR.
  - On wrap, the scan index advances and wraps DIGITS-1 -> 0.
- Output registers (one cycle of latency after a scan index change):
  - DSEL = ~(1 << index).
  - DOUT[6:0] = ~seg(digit[index]).
  - DOUT[7] = ~(index == DP_POS).
- The first valid digit-0 drive appears on the first CLK edge after RESET deasserts.
- seg() encodes 0..9 as standard a-g patterns; non-BCD values give all segments off. This case is unreachable but must be encoded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any displayed digit above DP_POS is blanked (DOUT = 8'hFF, DSEL still asserted) when it and every higher digit are 0.
  - Digits at or below DP_POS are never blanked.
- Undefined: every digit always shows its value.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE/RUN/STOP/LAP).
  - 7-segment constant table for 0..9 and blank.
  - function bcd_to_seg.
- Sub-module bcd_digit_cnt: one BCD digit with enable, carry-in and carry-out; instantiated DIGITS times via generate.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=2, DP_POS=2):
- Reset then idle 40 cycles -> count stays 0000; DSEL cycles 1110, 1101, 1011, 0111 every 2 cycles; DOUT = 8'hC0 (digit "0") with DOUT[7] = 0 only while DSEL = 1011.
- START_STOP pulse, then wait 40 cycles -> count 0010; RUNNING = 1.
- Preload near wrap by running 9999 ticks -> next tick gives 0000 and a single-cycle OVF pulse.
- Run to 0005, pulse LAP, run 20 more cycles -> display stays 0005, internal count 0010; pulse LAP again -> display shows the live value.
- START_STOP and CLEAR pulsed on the same cycle during RUN -> state IDLE, count 0000, RUNNING = 0.
- Assert RESET mid-count asynchronously (between clock edges) -> DOUT = 8'hFF and DSEL = 1111 immediately; the count reads 0 after release.
